// File: rtl/dmem_lsu.sv
// RV32 load/store unit in front of a 32-bit RAM port without byte enables.
// Sub-word stores use read-modify-write; misaligned/illegal requests error out.
module dmem_lsu #(
  parameter int SCALE = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_addr,
  input  logic             req_we,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  input  logic [31:0]      req_wdata,
  output logic             resp_valid,
  output logic [31:0]      resp_rdata,
  output logic             resp_err,
  output logic             mem_oe,
  output logic             mem_we,
  output logic [SCALE-1:0] mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RMW,
    S_DONE,
    S_ERR
  } state_e;

  state_e           state_q, state_d;
  logic [SCALE-1:0] addr_q, addr_d;
  logic [1:0]       off_q, off_d;
  logic [1:0]       size_q, size_d;
  logic             uns_q, uns_d;
  logic [15:0]      wdata_q, wdata_d;

  logic             accept;
  logic             bad;
  logic [4:0]       bsh;
  logic [7:0]       lane_b;
  logic [15:0]      lane_h;
  logic [31:0]      ld_data;
  logic [31:0]      merged;
  logic             unused_addr;

  assign unused_addr = ^req_addr[31:SCALE+2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      off_q   <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      off_q   <= off_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    bsh    = {off_q, 3'b000};
    lane_b = mem_rdata[bsh +: 8];
    lane_h = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    unique case (size_q)
      2'd0:    ld_data = {{24{~uns_q & lane_b[7]}}, lane_b};
      2'd1:    ld_data = {{16{~uns_q & lane_h[15]}}, lane_h};
      default: ld_data = mem_rdata;
    endcase
    merged = mem_rdata;
    if (size_q == 2'd0) begin
      merged[bsh +: 8] = wdata_q[7:0];
    end else if (off_q[1]) begin
      merged[31:16] = wdata_q;
    end else begin
      merged[15:0] = wdata_q;
    end
  end

  always_comb begin
    req_ready  = rst && (state_q == S_IDLE);
    accept     = req_valid & req_ready;
    bad        = (req_size == 2'd3)
               | ((req_size == 2'd1) & req_addr[0])
               | ((req_size == 2'd2) & (|req_addr[1:0]));
    state_d    = state_q;
    addr_d     = addr_q;
    off_d      = off_q;
    size_d     = size_q;
    uns_d      = uns_q;
    wdata_d    = wdata_q;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    mem_oe     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d  = req_addr[SCALE+1:2];
          off_d   = req_addr[1:0];
          size_d  = req_size;
          uns_d   = req_unsigned;
          wdata_d = req_wdata[15:0];
          if (bad) begin
            state_d = S_ERR;
          end else begin
            mem_oe   = 1'b1;
            mem_addr = req_addr[SCALE+1:2];
            if (!req_we) begin
              state_d = S_LOAD;
            end else if (req_size == 2'd2) begin
              mem_we    = 1'b1;
              mem_wdata = req_wdata;
              state_d   = S_DONE;
            end else begin
              state_d = S_RMW;
            end
          end
        end
      end
      S_LOAD: begin
        resp_valid = 1'b1;
        resp_rdata = ld_data;
        state_d    = S_IDLE;
      end
      S_RMW: begin
        mem_oe    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = merged;
        state_d   = S_DONE;
      end
      S_DONE: begin
        resp_valid = 1'b1;
        state_d    = S_IDLE;
      end
      S_ERR: begin
        resp_valid = 1'b1;
        resp_err   = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // No RAM access or response may escape while reset is asserted.
    if (!rst) begin
      resp_valid = 1'b0;
      resp_err   = 1'b0;
      resp_rdata = '0;
      mem_oe     = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: behavioural RAM on the port, response scoreboard.
// Expected responses are queued at accept and matched on resp_valid.
module tb_dmem_lsu;

  localparam int SCALE = 10;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [31:0]      req_addr = '0;
  logic             req_we = 1'b0;
  logic [1:0]       req_size = '0;
  logic             req_unsigned = 1'b0;
  logic [31:0]      req_wdata = '0;
  logic             resp_valid;
  logic [31:0]      resp_rdata;
  logic             resp_err;
  logic             mem_oe;
  logic             mem_we;
  logic [SCALE-1:0] mem_addr;
  logic [31:0]      mem_wdata;
  logic [31:0]      mem_rdata;

  dmem_lsu #(.SCALE(SCALE)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .mem_oe(mem_oe), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] ram [2**SCALE];
  logic [31:0] ram_rd = '0;
  assign mem_rdata = ram_rd;

  always @(posedge clk) begin
    if (mem_oe) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        ram_rd <= ram[mem_addr];
    end
  end

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   oe_cnt = 0;

  logic             acc_oe, acc_we;
  logic [SCALE-1:0] acc_addr;
  logic [31:0]      acc_wdata;
  int               acc_wait;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_oe) oe_cnt++;
    if (resp_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_resp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.tag, "_rdata"}, resp_rdata, e.rdata);
        chk({e.tag, "_err"}, {31'd0, resp_err}, {31'd0, e.err});
        chk({e.tag, "_lat"}, cyc, e.cyc);
      end
    end
  end

  task automatic do_req(input string tag, input logic we,
                        input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_err,
                        input int lat, input bit push);
    int n;
    @(posedge clk);
    #1;
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    n = 0;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      n++;
      if (n > 20) begin
        chk({tag, "_ready_timeout"}, 32'd0, 32'd1);
        break;
      end
    end
    acc_wait  = n;
    acc_oe    = mem_oe;
    acc_we    = mem_we;
    acc_addr  = mem_addr;
    acc_wdata = mem_wdata;
    if (push) sb.push_back('{tag, exp_rd, exp_err, cyc + lat});
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb.size(), 0);
  endtask

  logic [31:0] lbu_exp [4] = '{32'h0000_00EF, 32'h0000_00A5,
                               32'h0000_0001, 32'h0000_0080};
  logic [31:0] lb_exp  [4] = '{32'hFFFF_FFEF, 32'hFFFF_FFA5,
                               32'h0000_0001, 32'hFFFF_FF80};

  initial begin
    for (int i = 0; i < 2**SCALE; i++) ram[i] = '0;

    req_valid = 1'b1;
    req_addr  = 32'h10;
    req_size  = 2'd2;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_ready", {31'd0, req_ready}, 32'd0);
      chk("rst_oe", {31'd0, mem_oe}, 32'd0);
      chk("rst_resp", {31'd0, resp_valid}, 32'd0);
    end
    chk("rst_addr", {22'd0, mem_addr}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    req_valid = 1'b0;

    do_req("lw_init", 0, 2'd2, 0, 32'h10, 0, 32'h0, 0, 1, 1);
    chk("rst_first_accept", acc_wait, 0);

    do_req("sw", 1, 2'd2, 0, 32'h10, 32'hDEAD_BEEF, 32'h0, 0, 1, 1);
    chk("sw_we", {31'd0, acc_we}, 32'd1);
    chk("sw_addr", {22'd0, acc_addr}, 32'd4);
    chk("sw_wdata", acc_wdata, 32'hDEAD_BEEF);
    do_req("lw", 0, 2'd2, 0, 32'h10, 0, 32'hDEAD_BEEF, 0, 1, 1);

    do_req("sb", 1, 2'd0, 0, 32'h11, 32'h0000_00A5, 32'h0, 0, 2, 1);
    chk("sb_rd_oe", {31'd0, acc_oe}, 32'd1);
    chk("sb_rd_we", {31'd0, acc_we}, 32'd0);
    @(negedge clk);
    chk("sb_wr_we", {31'd0, mem_we}, 32'd1);
    chk("sb_wr_addr", {22'd0, mem_addr}, 32'd4);
    chk("sb_wr_data", mem_wdata, 32'hDEAD_A5EF);
    do_req("lb", 0, 2'd0, 0, 32'h11, 0, 32'hFFFF_FFA5, 0, 1, 1);
    do_req("lbu", 0, 2'd0, 1, 32'h11, 0, 32'h0000_00A5, 0, 1, 1);

    do_req("sh", 1, 2'd1, 0, 32'h12, 32'h1234_8001, 32'h0, 0, 2, 1);
    do_req("lh", 0, 2'd1, 0, 32'h12, 0, 32'hFFFF_8001, 0, 1, 1);
    do_req("lhu", 0, 2'd1, 1, 32'h12, 0, 32'h0000_8001, 0, 1, 1);
    do_req("lw_sh", 0, 2'd2, 0, 32'h10, 0, 32'h8001_A5EF, 0, 1, 1);
    do_req("lh_lo", 0, 2'd1, 0, 32'h10, 0, 32'hFFFF_A5EF, 0, 1, 1);
    for (int i = 0; i < 4; i++) begin
      do_req("lbu_lane", 0, 2'd0, 1, 32'h10 + i, 0, lbu_exp[i], 0, 1, 1);
      do_req("lb_lane", 0, 2'd0, 0, 32'h10 + i, 0, lb_exp[i], 0, 1, 1);
    end
    do_req("lw_wrap", 0, 2'd2, 0, 32'h0000_1010, 0, 32'h8001_A5EF, 0, 1, 1);

    drain();
    oe_cnt = 0;
    do_req("err_lw", 0, 2'd2, 0, 32'h13, 0, 32'h0, 1, 1, 1);
    do_req("err_sh", 1, 2'd1, 0, 32'h11, 32'hFFFF, 32'h0, 1, 1, 1);
    do_req("err_sz3", 1, 2'd3, 0, 32'h10, 32'h0, 32'h0, 1, 1, 1);
    drain();
    chk("err_no_oe", oe_cnt, 0);
    do_req("lw_after_err", 0, 2'd2, 0, 32'h10, 0, 32'h8001_A5EF, 0, 1, 1);

    do_req("sb_rst", 1, 2'd0, 0, 32'h10, 32'h0, 32'h0, 0, 2, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rmw_rst_we", {31'd0, mem_we}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    do_req("lw_after_rst", 0, 2'd2, 0, 32'h10, 0, 32'h8001_A5EF, 0, 1, 1);

    drain();
    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Load/store unit between the core's MEM stage and one port of the 32-bit data BARE RAM (`BARERAM`, WIDTH=32). It turns byte-addressed RV32 load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into word accesses on the RAM port. Loads are aligned and sign/zero-extended. The RAM has no byte enables, so sub-word stores are done as read-modify-write. Misaligned or illegal-size requests are rejected with an error response and never touch memory.

## Interface
- `SCALE`, 10, RAM word-address width; must match the RAM's `SCALE` (2**SCALE 32-bit words).
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high only in IDLE with `rst` high; a request is accepted when `req_valid & req_ready`.
- `req_addr`  in  32  byte address; bits above `SCALE+1` are ignored, so addresses wrap.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  0 byte, 1 half, 2 word, 3 illegal.
- `req_unsigned`  in  1  loads only: zero-extend instead of sign-extend.
- `req_wdata`  in  32  store data, right-justified.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  load result; 0 for stores and errors.
- `resp_err`  out  1  valid with `resp_valid`; misaligned or illegal size.
- `mem_oe`, `mem_we`  out  1 each  RAM port enable and write enable.
- `mem_addr`  out  SCALE  RAM word address, `req_addr[SCALE+1:2]`.
- `mem_wdata`  out  32  RAM write data.
- `mem_rdata`  in  32  RAM read data, valid the cycle after a read enable.

## Operation
- **States:** IDLE, LOAD, RMW, DONE, ERR.
- **Error check:** size 3, half with `addr[0]`=1, or word with `addr[1:0]`≠0. Result: IDLE→ERR with no RAM access.
- **Latch on accept:** a registered copy of the word address, byte offset `addr[1:0]`, size, unsigned flag and wdata.
- **IDLE, port drive:** RAM port outputs are driven combinationally from the request in the accept cycle.
  - Load: `mem_oe`=1, `mem_we`=0, go to LOAD.
  - Word store: `mem_oe`=1, `mem_we`=1, `mem_wdata`=`req_wdata`, go to DONE.
  - Sub-word store: `mem_oe`=1, `mem_we`=0, go to RMW.
- **LOAD:** `resp_valid`=1. `resp_rdata` is extracted combinationally from `mem_rdata` (little-endian):
  - byte lane = offset; half lane = `offset[1]`.
  - Sign-extend from bit 7 or 15 unless unsigned; word passes through unchanged.
  - Next state IDLE.
- **RMW:** `mem_oe`=1, `mem_we`=1, same word address. `mem_wdata` = `mem_rdata` with the addressed lane replaced:
  - byte: bits [8*off+7:8*off] ← wdata[7:0];
  - half: bits [16*off[1]+15:16*off[1]] ← wdata[15:0].
  - Next state DONE.
- **DONE:** `resp_valid`=1, `resp_err`=0, `resp_rdata`=0; next state IDLE.
- **ERR:** `resp_valid`=1, `resp_err`=1, `resp_rdata`=0; next state IDLE.
- **Port idle:** `mem_oe`=0 in DONE, ERR, and in IDLE without an accept. `mem_we`=1 only when `mem_oe`=1.

## Timing
- **Latency from accept cycle T:**
  - load, word store and error respond at T+1;
  - sub-word store writes RAM at the T+1 edge and responds at T+2.
- **Throughput:** one request per 2 cycles (word ops) or 3 cycles (sub-word stores); `req_ready`=0 outside IDLE.
- **Request stability:** request fields only need to be stable in the accept cycle.
- **Reset values (while `rst` low):** state IDLE, latched registers 0. Outputs: `req_ready`=0, `resp_valid`=0, `resp_err`=0, `resp_rdata`=0, `mem_oe`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
- **Gating:** port outputs are gated by `rst`, so no RAM access is issued at any edge where `rst` is low.
- **Reset mid-operation:**
  - The transaction is dropped with no response.
  - Reset in RMW: the write is not performed and the RAM word is unchanged.
  - Reset in LOAD: the response is lost.
- **Back-to-back requests:** a request held through a non-IDLE cycle is accepted in the next IDLE cycle. A store followed by a load to the same word returns the stored value, since the RAM write completes before the load reads.

## Test plan
- **Reset:** `rst`=0 with `req_valid`=1 → `req_ready`=0, `mem_oe`=0, `resp_valid`=0 for all cycles; after release, first accept on the next IDLE cycle.
- **Word store then load:** SW 0xDEADBEEF @0x10, then LW @0x10.
  - SW → `mem_we`=1 and `mem_addr`=4 at T, response at T+1.
  - LW → `resp_rdata`=0xDEADBEEF at T+1.
- **Byte store and byte loads:** SB 0xA5 @0x11 over 0xDEADBEEF.
  - T: read. T+1: write 0xDEADA5EF. T+2: `resp_valid`.
  - LB @0x11 → 0xFFFFFFA5; LBU → 0x000000A5.
- **Half store and half loads:** SH 0x8001 @0x12 → word 0x8001A5EF; LH @0x12 → 0xFFFF8001; LHU → 0x00008001; LW @0x10 → 0x8001A5EF.
- **Errors:** LW @0x13, SH @0x11, size=3 @0x10 → each gives `resp_valid`=1, `resp_err`=1, `resp_rdata`=0 at T+1, with `mem_oe` never high; the word @0x10 is unchanged.
- **Reset during RMW:** SB 0x00 @0x10 with `rst` pulsed low in the RMW cycle → no write, no response; a subsequent LW @0x10 returns the prior value.
